// File: rtl/lcd_text_buffer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lcd_text_buffer_if : byte stream, character read port and driver handshake
// Revision 1.0
// ---------------------------------------------------------------------------
interface lcd_text_buffer_if #(
  parameter int ADDR_BITS = 6
);
  logic                 in_valid;
  logic                 in_ready;
  logic [7:0]           in_data;
  logic [ADDR_BITS-1:0] rdaddr;
  logic [7:0]           rddata;
  logic                 lcd_busy;
  logic                 lcd_trg;
  logic [ADDR_BITS-1:0] cursor;
  logic                 dirty;

  modport slave (
    input  in_valid, in_data, rdaddr, lcd_busy,
    output in_ready, rddata, lcd_trg, cursor, dirty
  );

  modport master (
    output in_valid, in_data, rdaddr, lcd_busy,
    input  in_ready, rddata, lcd_trg, cursor, dirty
  );
endinterface
`default_nettype wire

// File: rtl/lcd_text_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lcd_text_buffer : 4x16 character frame buffer with refresh scheduling for an
// HD44780 driver. Control-character handling enabled by LCD_TEXT_BUFFER_CTRL_EN.
// Revision 1.0
// ---------------------------------------------------------------------------
module lcd_text_buffer #(
  parameter int LINE_WIDTH      = 16,
  parameter int LINES           = 4,
  parameter int ADDR_BITS       = 6,
  parameter int REFRESH_HOLDOFF = 250
) (
  input  logic             clk,
  input  logic             rst,
  lcd_text_buffer_if.slave bus
);
  localparam int DEPTH     = LINE_WIDTH * LINES;
  localparam int HOLD_BITS = (REFRESH_HOLDOFF > 0) ? $clog2(REFRESH_HOLDOFF + 1) : 1;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);
  localparam logic [HOLD_BITS-1:0] HOLD_MAX  = HOLD_BITS'(REFRESH_HOLDOFF);
  localparam logic [7:0]           BLANK     = 8'h20;

  typedef enum logic [2:0] {
    R_IDLE = 3'd0,
    R_HOLD = 3'd1,
    R_WAIT = 3'd2,
    R_TRIG = 3'd3,
    R_ARM  = 3'd4
  } rstate_t;

  logic [7:0]           mem_q [DEPTH];
  logic [7:0]           mem_d [DEPTH];
  logic [ADDR_BITS-1:0] cursor_q, cursor_d;
  logic                 dirty_q, dirty_d;
  logic [HOLD_BITS-1:0] hold_q, hold_d;
  rstate_t              rstate_q, rstate_d;

  logic                 accept;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_waddr;
  logic [7:0]           mem_wdata;
  logic                 write_quiet;
  logic [ADDR_BITS-1:0] cursor_inc;

  assign accept     = bus.in_valid && bus.in_ready;
  assign cursor_inc = (cursor_q == LAST_ADDR) ? '0 : cursor_q + ADDR_BITS'(1);

`ifdef LCD_TEXT_BUFFER_CTRL_EN
  localparam logic [ADDR_BITS-1:0] LINE_STEP = ADDR_BITS'(LINE_WIDTH);
  localparam logic [ADDR_BITS-1:0] LAST_LINE = ADDR_BITS'((LINES - 1) * LINE_WIDTH);

  typedef enum logic [0:0] {
    W_RUN   = 1'b0,
    W_CLEAR = 1'b1
  } wstate_t;

  wstate_t              wstate_q, wstate_d;
  logic [ADDR_BITS-1:0] clr_addr_q, clr_addr_d;
  logic [ADDR_BITS-1:0] col;
  logic [ADDR_BITS-1:0] line_base;

  assign col          = cursor_q % LINE_STEP;
  assign line_base    = cursor_q - col;
  assign bus.in_ready = (wstate_q == W_RUN);

  always_comb begin
    wstate_d   = wstate_q;
    clr_addr_d = clr_addr_q;
    cursor_d   = cursor_q;
    mem_we     = 1'b0;
    mem_waddr  = cursor_q;
    mem_wdata  = bus.in_data;
    if (wstate_q == W_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr_q;
      mem_wdata = BLANK;
      if (clr_addr_q == LAST_ADDR) begin
        wstate_d   = W_RUN;
        clr_addr_d = '0;
        cursor_d   = '0;
      end else begin
        clr_addr_d = clr_addr_q + ADDR_BITS'(1);
      end
    end else if (accept) begin
      case (bus.in_data)
        8'h0A: cursor_d = (line_base == LAST_LINE) ? '0 : line_base + LINE_STEP;
        8'h0D: cursor_d = line_base;
        8'h08: if (col != '0) cursor_d = cursor_q - ADDR_BITS'(1);
        8'h0C: begin
          wstate_d   = W_CLEAR;
          clr_addr_d = '0;
        end
        default: begin
          if (bus.in_data >= 8'h20 && bus.in_data <= 8'h7E) begin
            mem_we   = 1'b1;
            cursor_d = cursor_inc;
          end
        end
      endcase
    end
  end

  // Entering CLEAR counts as activity so a refresh cannot fire on its first cycle.
  assign write_quiet = !mem_we && (wstate_d == W_RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wstate_q   <= W_RUN;
      clr_addr_q <= '0;
    end else begin
      wstate_q   <= wstate_d;
      clr_addr_q <= clr_addr_d;
    end
  end
`else
  assign bus.in_ready = 1'b1;

  always_comb begin
    cursor_d  = cursor_q;
    mem_we    = accept;
    mem_waddr = cursor_q;
    mem_wdata = bus.in_data;
    if (accept) cursor_d = cursor_inc;
  end

  assign write_quiet = !mem_we;
`endif

  always_comb begin
    mem_d = mem_q;
    if (mem_we) mem_d[mem_waddr] = mem_wdata;
  end

  // Holdoff counts quiet cycles since the last write and saturates at the limit.
  always_comb begin
    if (mem_we)                hold_d = '0;
    else if (hold_q == HOLD_MAX) hold_d = hold_q;
    else                       hold_d = hold_q + HOLD_BITS'(1);
  end

  always_comb begin
    rstate_d = rstate_q;
    case (rstate_q)
      R_IDLE: if (dirty_q) rstate_d = R_HOLD;
      R_HOLD: if (hold_q == HOLD_MAX && write_quiet) rstate_d = R_WAIT;
      R_WAIT: begin
        if (!write_quiet)      rstate_d = R_HOLD;
        else if (!bus.lcd_busy) rstate_d = R_TRIG;
      end
      R_TRIG: rstate_d = R_ARM;
      R_ARM:  if (bus.lcd_busy) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    dirty_d = dirty_q;
    if (mem_we)                  dirty_d = 1'b1;
    else if (rstate_d == R_TRIG) dirty_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= BLANK;
      cursor_q <= '0;
      dirty_q  <= 1'b0;
      hold_q   <= '0;
      rstate_q <= R_IDLE;
    end else begin
      mem_q    <= mem_d;
      cursor_q <= cursor_d;
      dirty_q  <= dirty_d;
      hold_q   <= hold_d;
      rstate_q <= rstate_d;
    end
  end

  assign bus.rddata  = mem_q[bus.rdaddr];
  assign bus.lcd_trg = (rstate_q == R_TRIG);
  assign bus.cursor  = cursor_q;
  assign bus.dirty   = dirty_q;
endmodule
`default_nettype wire

// File: tb/tb_lcd_text_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_lcd_text_buffer : scoreboard bench for lcd_text_buffer
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_lcd_text_buffer;
  localparam int LW      = 16;
  localparam int LN      = 4;
  localparam int AB      = 6;
  localparam int HOLDOFF = 250;
  localparam int DEPTH   = LW * LN;
`ifdef LCD_TEXT_BUFFER_CTRL_EN
  localparam bit CTRL = 1'b1;
`else
  localparam bit CTRL = 1'b0;
`endif

  typedef struct {
    int         addr;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lcd_text_buffer_if #(.ADDR_BITS(AB)) bus ();

  lcd_text_buffer #(
    .LINE_WIDTH     (LW),
    .LINES          (LN),
    .ADDR_BITS      (AB),
    .REFRESH_HOLDOFF(HOLDOFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t       sb[$];
  logic [7:0] model_mem [DEPTH];
  int         model_cur = 0;
  int         n_checks = 0, n_pass = 0;
  int         cyc = 0, trg_count = 0, trg_cyc = -1, trg_viol = 0;
  logic       trg_prev = 1'b0;
  int         drv_left = 0;
  bit         auto_drv = 1'b1;
  int         acc_cyc = 0, last_waits = 0, ready_cursor = 0;

  task automatic check(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, actual, actual, expected, expected);
  endtask

  // One clock; watches the trigger and plays the driver's busy response.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.lcd_trg) begin
      trg_count++;
      trg_cyc = cyc;
      if (bus.lcd_busy || trg_prev) trg_viol++;
      if (auto_drv) drv_left = 20;
    end
    trg_prev = bus.lcd_trg;
    if (auto_drv) begin
      bus.lcd_busy = (drv_left > 0);
      if (drv_left > 0) drv_left--;
    end
  endtask

  task automatic model_write(input int a, input logic [7:0] d);
    model_mem[a] = d;
    for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].addr == a) sb.delete(i);
    sb.push_back('{addr: a, data: d});
  endtask

  task automatic model_byte(input logic [7:0] b);
`ifdef LCD_TEXT_BUFFER_CTRL_EN
    if (b >= 8'h20 && b <= 8'h7E) begin
      model_write(model_cur, b);
      model_cur = (model_cur + 1) % DEPTH;
    end else if (b == 8'h0A) model_cur = ((model_cur / LW + 1) % LN) * LW;
    else if (b == 8'h0D) model_cur = (model_cur / LW) * LW;
    else if (b == 8'h08) begin
      if (model_cur % LW != 0) model_cur--;
    end else if (b == 8'h0C) begin
      for (int i = 0; i < DEPTH; i++) model_write(i, 8'h20);
      model_cur = 0;
    end
`else
    model_write(model_cur, b);
    model_cur = (model_cur + 1) % DEPTH;
`endif
  endtask

  task automatic send(input logic [7:0] b);
    int waits = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && waits < 200) begin
      tick();
      waits++;
    end
    last_waits   = waits;
    ready_cursor = bus.cursor;
    if (!bus.in_ready) begin
      check("ready_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    tick();
    acc_cyc      = cyc;
    bus.in_valid = 1'b0;
    model_byte(b);
    if (!(CTRL && b == 8'h0C)) check("cursor", bus.cursor, model_cur);
  endtask

  // Pops each expected glyph and reads it back through the combinational port.
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.rdaddr = AB'(e.addr);
      tick();
      check($sformatf("mem[%0d]", e.addr), bus.rddata, e.data);
    end
  endtask

  task automatic wait_trg(input int base, input int budget);
    int k = 0;
    while (trg_count == base && k < budget) begin
      tick();
      k++;
    end
    if (trg_count == base) check("trg_timeout", 0, 1);
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_write(i, 8'h20);
    model_cur = 0;
  endtask

  initial begin
    int n, w, b;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.rdaddr   = '0;
    bus.lcd_busy = 1'b0;
    rst          = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h20;
    repeat (3) tick();
    check("rst_ready", bus.in_ready, 1);
    check("rst_cursor", bus.cursor, 0);
    check("rst_dirty", bus.dirty, 0);
    check("rst_trg", bus.lcd_trg, 0);
    rst = 1'b1;
    tick();
    model_write(0, 8'h20);
    model_write(17, 8'h20);
    model_write(63, 8'h20);
    drain();

    // "HI" and refresh latency
    n = trg_count;
    send(8'h48);
    send(8'h49);
    w = acc_cyc;
    check("hi_dirty", bus.dirty, 1);
    drain();
    wait_trg(n, 400);
    check("hi_trg_lat", trg_cyc - w, HOLDOFF + 2);
    check("hi_trg_dirty", bus.dirty, 0);
    repeat (60) tick();
    check("hi_trg_once", trg_count - n, 1);

`ifdef LCD_TEXT_BUFFER_CTRL_EN
    send(8'h0D);
    check("cr_no_dirty", bus.dirty, 0);
    send(8'h41);
    send(8'h0A);
    send(8'h42);
    check("nl_cursor", bus.cursor, 17);
    drain();
    send(8'h08);
    send(8'h08);
`endif
    // Config-dependent bytes, then fill up to the last address and wrap
    send(8'h0A);
    send(8'hFF);
    while (model_cur != DEPTH - 1) send(8'h30 + 8'(model_cur % 10));
    send(8'h43);
    check("wrap_cursor", bus.cursor, 0);
    drain();
    n = trg_count;
    wait_trg(n, 400);
    repeat (40) tick();

`ifdef LCD_TEXT_BUFFER_CTRL_EN
    send(8'h41);
    send(8'h0C);
    send(8'h55);
    check("clr_ready_low", last_waits, DEPTH);
    check("clr_cursor", ready_cursor, 0);
    drain();
`endif
    repeat (300) tick();

    // Busy driver blocks the trigger; write during print gives one more refresh
    auto_drv     = 1'b0;
    bus.lcd_busy = 1'b1;
    n            = trg_count;
    send(8'h61);
    repeat (300) tick();
    check("busy_no_trg", trg_count - n, 0);
    check("busy_dirty", bus.dirty, 1);
    b = cyc;
    bus.lcd_busy = 1'b0;
    tick();
    check("busy_drop_trg", trg_count - n, 1);
    check("busy_drop_cyc", trg_cyc, b + 1);
    bus.lcd_busy = 1'b1;
    repeat (5) tick();
    send(8'h62);
    check("print_dirty", bus.dirty, 1);
    repeat (300) tick();
    check("print_no_trg", trg_count - n, 1);
    b = cyc;
    bus.lcd_busy = 1'b0;
    tick();
    check("print_retrig", trg_count - n, 2);
    check("print_retrig_cyc", trg_cyc, b + 1);
    bus.lcd_busy = 1'b1;
    repeat (3) tick();
    bus.lcd_busy = 1'b0;
    repeat (300) tick();
    check("print_once", trg_count - n, 2);
    auto_drv = 1'b1;

    // Writes every 100 cycles keep restarting the holdoff
    n = trg_count;
    for (int k = 0; k < 4; k++) begin
      send(8'h70 + 8'(k));
      if (k < 3) repeat (99) tick();
    end
    w = acc_cyc;
    check("spaced_no_trg", trg_count - n, 0);
    wait_trg(n, 400);
    check("spaced_lat", trg_cyc - w, HOLDOFF + 2);
    repeat (40) tick();

    // Asynchronous reset in the middle of activity
`ifdef LCD_TEXT_BUFFER_CTRL_EN
    send(8'h0C);
    repeat (19) tick();
`else
    send(8'h41);
    repeat (100) tick();
`endif
    rst = 1'b0;
    #1;
    check("arst_cursor", bus.cursor, 0);
    check("arst_dirty", bus.dirty, 0);
    check("arst_ready", bus.in_ready, 1);
    check("arst_trg", bus.lcd_trg, 0);
    model_reset();
    tick();
    tick();
    rst = 1'b1;
    n = trg_count;
    drain();
    repeat (300) tick();
    check("post_rst_no_trg", trg_count - n, 0);
    check("post_rst_dirty", bus.dirty, 0);
    check("trg_rules", trg_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end
endmodule
`default_nettype wire
